// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : RV32I decode stage: DEPTH-entry {pc, inst} FIFO feeding a
//               registered decode output with valid/ready handshake and flush.
//               Optional macro DECODE_ILLEGAL_TRAP_EN enables illegal flagging.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      shamt,
    output logic [2:0]      fmt,
    output logic            illegal
);

    localparam int           c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0] c_depth = (c_aw+1)'(DEPTH);
    localparam logic [2:0]   c_fmt_r = 3'd0, c_fmt_i = 3'd1, c_fmt_s = 3'd2,
                             c_fmt_b = 3'd3, c_fmt_u = 3'd4, c_fmt_j = 3'd5,
                             c_fmt_x = 3'd6;

    logic [XLEN-1:0] r_pc_mem   [DEPTH];
    logic [31:0]     r_inst_mem [DEPTH];
    logic [c_aw-1:0] r_wptr, r_rptr;
    logic [c_aw:0]   r_count;

    logic w_full, w_push, w_load;
    assign w_full   = (r_count == c_depth);
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full && !flush;
    assign w_load   = (r_count != '0) && (!out_valid || out_ready) && !flush;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_pc_mem[r_wptr]   <= in_pc;
            r_inst_mem[r_wptr] <= in_inst;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_load) r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_load)      r_count <= r_count + 1'b1;
            else if (!w_push && w_load) r_count <= r_count - 1'b1;
        end
    end

    // Combinational decode of the FIFO head
    logic [31:0]     w_inst;
    logic [4:0]      w_rd, w_rs1, w_rs2, w_shamt;
    logic [2:0]      w_funct3, w_fmt;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;

    assign w_inst = r_inst_mem[r_rptr];

    always_comb begin
        w_rd     = '0;
        w_rs1    = '0;
        w_rs2    = '0;
        w_funct3 = '0;
        w_funct7 = '0;
        w_shamt  = '0;
        w_imm    = '0;
        w_fmt    = c_fmt_x;
        case (w_inst[6:0])
            7'b0110011: begin
                w_fmt = c_fmt_r;  w_rd = w_inst[11:7]; w_rs1 = w_inst[19:15];
                w_rs2 = w_inst[24:20]; w_funct3 = w_inst[14:12]; w_funct7 = w_inst[31:25];
            end
            7'b0010011: begin
                w_fmt = c_fmt_i;  w_rd = w_inst[11:7]; w_rs1 = w_inst[19:15];
                w_funct3 = w_inst[14:12];
                if (w_inst[13:12] == 2'b01) begin
                    w_shamt  = w_inst[24:20];
                    w_funct7 = w_inst[31:25];
                end else begin
                    w_imm = XLEN'($signed(w_inst[31:20]));
                end
            end
            7'b0000011, 7'b1100111, 7'b1110011: begin
                w_fmt = c_fmt_i;  w_rd = w_inst[11:7]; w_rs1 = w_inst[19:15];
                w_funct3 = w_inst[14:12];
                w_imm = XLEN'($signed(w_inst[31:20]));
            end
            7'b0100011: begin
                w_fmt = c_fmt_s;  w_rs1 = w_inst[19:15]; w_rs2 = w_inst[24:20];
                w_funct3 = w_inst[14:12];
                w_imm = XLEN'($signed({w_inst[31:25], w_inst[11:7]}));
            end
            7'b1100011: begin
                w_fmt = c_fmt_b;  w_rs1 = w_inst[19:15]; w_rs2 = w_inst[24:20];
                w_funct3 = w_inst[14:12];
                w_imm = XLEN'($signed({w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                w_fmt = c_fmt_u;  w_rd = w_inst[11:7];
                w_imm = XLEN'($signed({w_inst[31:12], 12'b0}));
            end
            7'b1101111: begin
                w_fmt = c_fmt_j;  w_rd = w_inst[11:7];
                w_imm = XLEN'($signed({w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0}));
            end
            default: ;
        endcase
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    always_comb begin
        w_illegal = 1'b0;
        if (w_fmt == c_fmt_x)
            w_illegal = 1'b1;
        else if (w_inst[6:0] == 7'b0110011)
            w_illegal = (w_funct7 != 7'h00) && (w_funct7 != 7'h20);
        else if (w_inst[6:0] == 7'b0010011 && w_funct3 == 3'b001)
            w_illegal = (w_funct7 != 7'h00);
        else if (w_inst[6:0] == 7'b0010011 && w_funct3 == 3'b101)
            w_illegal = (w_funct7 != 7'h00) && (w_funct7 != 7'h20);
    end
`else
    assign w_illegal = 1'b0;
`endif

    // Output register: flush clears valid only, fields retain their values
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            opcode    <= '0;
            rd        <= '0;
            rs1       <= '0;
            rs2       <= '0;
            funct3    <= '0;
            funct7    <= '0;
            imm       <= '0;
            shamt     <= '0;
            fmt       <= c_fmt_x;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_load) begin
            out_valid <= 1'b1;
            out_pc    <= r_pc_mem[r_rptr];
            opcode    <= w_inst[6:0];
            rd        <= w_rd;
            rs1       <= w_rs1;
            rs2       <= w_rs2;
            funct3    <= w_funct3;
            funct7    <= w_funct7;
            imm       <= w_imm;
            shamt     <= w_shamt;
            fmt       <= w_fmt;
            illegal   <= w_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed self-checking bench for decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic c_ill = 1'b1;
`else
    localparam logic c_ill = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [XLEN-1:0] in_pc, out_pc, imm;
    logic [31:0]     in_inst;
    logic [6:0]      opcode, funct7;
    logic [4:0]      rd, rs1, rs2, shamt;
    logic [2:0]      funct3, fmt;
    logic            illegal;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .shamt(shamt), .fmt(fmt), .illegal(illegal)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push one instruction into an empty pipe; it must be valid after two edges
    task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1; in_pc = pc; in_inst = inst;
        step();
        in_valid = 1'b0;
        chk("latency_not_yet", {63'd0, out_valid}, 64'd0);
        step();
        chk("latency_valid", {63'd0, out_valid}, 64'd1);
        chk("out_pc", {32'd0, out_pc}, {32'd0, pc});
    endtask

    function automatic logic [31:0] addi_enc(input int i);
        return (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13;
    endfunction

    initial begin
        int accepted;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        step(); step();
        reset = 1'b0;

        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_fmt", {61'd0, fmt}, 64'd6);
        chk("rst_imm", {32'd0, imm}, 64'd0);
        chk("rst_illegal", {63'd0, illegal}, 64'd0);

        // addi x1,x2,-1
        out_ready = 1'b1;
        push_one(32'h100, 32'hFFF10093);
        chk("addi_rd", {59'd0, rd}, 64'd1);
        chk("addi_rs1", {59'd0, rs1}, 64'd2);
        chk("addi_funct3", {61'd0, funct3}, 64'd0);
        chk("addi_imm", {32'd0, imm}, 64'hFFFFFFFF);
        chk("addi_fmt", {61'd0, fmt}, 64'd1);

        // jal x1,-4
        push_one(32'h104, 32'hFFDFF0EF);
        chk("jal_rd", {59'd0, rd}, 64'd1);
        chk("jal_imm", {32'd0, imm}, 64'hFFFFFFFC);
        chk("jal_fmt", {61'd0, fmt}, 64'd5);
        chk("jal_rs1", {59'd0, rs1}, 64'd0);
        chk("jal_rs2", {59'd0, rs2}, 64'd0);
        chk("jal_funct3", {61'd0, funct3}, 64'd0);

        // srai x5,x6,3
        push_one(32'h108, 32'h40335293);
        chk("srai_rd", {59'd0, rd}, 64'd5);
        chk("srai_rs1", {59'd0, rs1}, 64'd6);
        chk("srai_funct3", {61'd0, funct3}, 64'd5);
        chk("srai_shamt", {59'd0, shamt}, 64'd3);
        chk("srai_funct7", {57'd0, funct7}, 64'h20);
        chk("srai_imm", {32'd0, imm}, 64'd0);
        chk("srai_illegal", {63'd0, illegal}, 64'd0);
        step();
        chk("drain_idle", {63'd0, out_valid}, 64'd0);

        // Back-pressure: offer DEPTH+2, expect DEPTH+1 accepted
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            in_valid = 1'b1; in_pc = 32'h200 + 32'(4 * i); in_inst = addi_enc(i);
            if (in_ready) accepted++;
            if (i == DEPTH + 1) chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            step();
        end
        in_valid = 1'b0;
        chk("bp_accepted", 64'(accepted), 64'(DEPTH + 1));
        chk("bp_stall_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_stall_pc", {32'd0, out_pc}, 64'h200);
        step();
        chk("bp_stall_pc_hold", {32'd0, out_pc}, 64'h200);
        chk("bp_stall_imm_hold", {32'd0, imm}, 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k <= DEPTH; k++) begin
            chk("drain_valid", {63'd0, out_valid}, 64'd1);
            chk("drain_pc", {32'd0, out_pc}, 64'(32'h200 + 32'(4 * k)));
            chk("drain_rd", {59'd0, rd}, 64'(k + 1));
            chk("drain_imm", {32'd0, imm}, 64'(k));
            step();
        end
        chk("drain_done", {63'd0, out_valid}, 64'd0);

        // Flush with full FIFO and a held output
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            in_valid = 1'b1; in_pc = 32'h300 + 32'(4 * i); in_inst = addi_enc(i);
            step();
        end
        chk("pre_flush_full", {63'd0, in_ready}, 64'd0);
        chk("pre_flush_valid", {63'd0, out_valid}, 64'd1);
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h400; in_inst = addi_enc(7);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_pc_kept", {32'd0, out_pc}, 64'h300);
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH + 2; k++) begin
            step();
            chk("flush_nothing_out", {63'd0, out_valid}, 64'd0);
        end

        // Invalid opcode
        push_one(32'h500, 32'h00000000);
        chk("inv_fmt", {61'd0, fmt}, 64'd6);
        chk("inv_rd", {59'd0, rd}, 64'd0);
        chk("inv_rs1", {59'd0, rs1}, 64'd0);
        chk("inv_imm", {32'd0, imm}, 64'd0);
        chk("inv_opcode", {57'd0, opcode}, 64'd0);
        chk("inv_illegal", {63'd0, illegal}, {63'd0, c_ill});

        // R-type with funct7 = 0x01 (mul x3,x1,x2)
        push_one(32'h504, 32'h022081B3);
        chk("r_fmt", {61'd0, fmt}, 64'd0);
        chk("r_rd", {59'd0, rd}, 64'd3);
        chk("r_rs1", {59'd0, rs1}, 64'd1);
        chk("r_rs2", {59'd0, rs2}, 64'd2);
        chk("r_funct7", {57'd0, funct7}, 64'd1);
        chk("r_imm", {32'd0, imm}, 64'd0);
        chk("r_illegal", {63'd0, illegal}, {63'd0, c_ill});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Pipelined, parametrised RV32I decode stage that sits between fetch and execute. An instruction FIFO of DEPTH {pc, inst} entries absorbs fetch bursts. Decoded fields go into an output register with a valid/ready handshake. The stage adds back-pressure, flush, full immediate generation for all formats (J-type sign-extended), a format code, and optional illegal-instruction flagging.

Parameters:
XLEN, 32, width of pc and imm; legal values 32 or 64; U/I/S/B/J immediates sign-extend to XLEN.
DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
flush  in  1  discard all buffered and output-register contents
in_valid  in  1  fetch offers in_pc/in_inst
in_ready  out  1  FIFO can accept; equals !full
in_pc  in  XLEN  instruction address
in_inst  in  32  instruction word
out_valid  out  1  decoded instruction present
out_ready  in  1  execute accepts
out_pc  out  XLEN  pc of decoded instruction
opcode  out  7  inst[6:0]
rd, rs1, rs2  out  5 each  register indices; 0 when unused by the format
funct3  out  3  0 when unused
funct7  out  7  inst[31:25] for R-type and OP-IMM shifts; else 0
imm  out  XLEN  generated immediate; 0 when unused
shamt  out  5  inst[24:20] for OP-IMM funct3 001/101; else 0
fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 6=invalid
illegal  out  1  see Optional Feature

Behaviour:
- Reset: FIFO empty, count 0, read/write pointers 0. out_valid 0. All output fields 0. fmt=6, illegal=0, in_ready=1.
- Push when in_valid && in_ready. No push when full, even if a pop occurs in the same cycle.
- Load condition: output register loads the FIFO head when FIFO is non-empty and (!out_valid || out_ready).
  - On load, out_valid becomes 1.
  - If out_ready && out_valid and the FIFO is empty, out_valid becomes 0.
- Latency: instruction accepted at edge N appears with out_valid=1 after edge N+1 when the pipe is empty. Throughput is 1/cycle. FIFO order is preserved.
- Output fields hold stable while out_valid && !out_ready.
- Flush (priority over push/pop/load): at the next edge the FIFO empties and out_valid becomes 0. Fields keep their last values. A simultaneous in_valid is dropped. in_ready is 1 the cycle after flush.
- reset dominates flush.
- Decode is combinational on the FIFO head, registered into the outputs:
  - 0110011 R: rd, rs1, rs2, funct3, funct7.
  - 0010011 OP-IMM:
    - funct3 001/101: rd, rs1, funct3, shamt, funct7; imm=0.
    - otherwise: imm = sext(inst[31:20]), funct7=0.
  - 0000011 load, 1100111 JALR, 1110011 SYSTEM: I-format; rd, rs1, funct3, imm = sext(inst[31:20]).
  - 0100011 S: rs1, rs2, funct3, imm = sext({inst[31:25], inst[11:7]}).
  - 1100011 B: rs1, rs2, funct3, imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - 0110111 LUI, 0010111 AUIPC: rd, imm = sext({inst[31:12], 12'b0}).
  - 1101111 J: rd, imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - Any other opcode, or inst[1:0] != 11: all fields 0 except opcode and pc; fmt=6.
- Pointer wrap-around is modulo DEPTH. Count is $clog2(DEPTH)+1 bits; full when count==DEPTH.

Optional Feature:
DECODE_ILLEGAL_TRAP_EN
- Defined: illegal=1 for fmt=6 entries.
  - Also illegal=1 for R-type with funct7 not in {0x00, 0x20}.
  - Also illegal=1 for OP-IMM funct3 001 with funct7 != 0x00.
  - Also illegal=1 for OP-IMM funct3 101 with funct7 not in {0x00, 0x20}.
  - Illegal instructions still flow through the handshake normally.
- Undefined: illegal tied to 0; decode otherwise identical.

Test Plan:
1. Reset, push pc=0x100, inst=0xFFF10093 (addi x1,x2,-1), out_ready=1 -> out_valid two edges later; out_pc=0x100, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF, fmt=1.
2. Push 0xFFDFF0EF (jal x1,-4) -> rd=1, imm=0xFFFFFFFC, fmt=5, rs1=rs2=funct3=0.
3. Push 0x40335293 (srai x5,x6,3) -> rd=5, rs1=6, funct3=5, shamt=3, funct7=0x20, imm=0.
4. out_ready=0, offer DEPTH+2 instructions -> DEPTH+1 accepted, in_ready=0; outputs stable. Raise out_ready -> all emitted in order, one per cycle.
5. Full FIFO plus out_valid=1; assert flush together with in_valid -> next cycle out_valid=0, in_ready=1; nothing emitted later.
6. Push 0x00000000 -> fmt=6, fields 0, illegal=1 with DECODE_ILLEGAL_TRAP_EN and 0 without. Push R-type funct7=0x01 -> illegal=1 only with the macro defined.
